// File: rtl/bp_update_if.sv
// Signal bundle between EX, the branch predictor and the update scheduler.
// The optional counters are present only when BP_UPDQ_STATS_EN is defined.
interface bp_update_if #(
    parameter int s_index = 4
);
    logic               ex_valid;
    logic [31:0]        ex_pc;
    logic [31:0]        ex_dest;
    logic               ex_taken;
    logic               ex_ready;
    logic               pred_stall;
    logic               clear_req;
    logic               clear_busy;
    logic               w_br_op;
    logic [31:0]        w_pc;
    logic [31:0]        w_dest;
    logic               w_taken;
    logic               clr_load;
    logic [s_index-1:0] clr_index;
`ifdef BP_UPDQ_STATS_EN
    logic [31:0]        stat_updates;
    logic [31:0]        stat_bp_cycles;
`endif

    // master is the EX/predictor environment; slave is the scheduler itself.
`ifdef BP_UPDQ_STATS_EN
    modport master (
        output ex_valid, ex_pc, ex_dest, ex_taken, pred_stall, clear_req,
        input  ex_ready, clear_busy, w_br_op, w_pc, w_dest, w_taken,
               clr_load, clr_index, stat_updates, stat_bp_cycles
    );
    modport slave (
        input  ex_valid, ex_pc, ex_dest, ex_taken, pred_stall, clear_req,
        output ex_ready, clear_busy, w_br_op, w_pc, w_dest, w_taken,
               clr_load, clr_index, stat_updates, stat_bp_cycles
    );
`else
    modport master (
        output ex_valid, ex_pc, ex_dest, ex_taken, pred_stall, clear_req,
        input  ex_ready, clear_busy, w_br_op, w_pc, w_dest, w_taken,
               clr_load, clr_index
    );
    modport slave (
        input  ex_valid, ex_pc, ex_dest, ex_taken, pred_stall, clear_req,
        output ex_ready, clear_busy, w_br_op, w_pc, w_dest, w_taken,
               clr_load, clr_index
    );
`endif
endinterface

// File: rtl/bp_update_ctrl.sv
// Branch predictor update scheduler: in-order update FIFO plus full-table clear walk.
// Define BP_UPDQ_STATS_EN to add the write and backpressure counters.
//
// state    | meaning
// ---------+---------------------------------------------------------
// st_run   | accept updates from EX, drain FIFO head into predictor
// st_clear | walk clr_index over every predictor entry, no updates
module bp_update_ctrl #(
    parameter int s_index = 4,
    parameter int depth   = 4
) (
    input  logic        clk,
    input  logic        rst,
    bp_update_if.slave  bus
);
    localparam int aw = $clog2(depth);

    localparam logic [0:0] st_run   = 1'b0;
    localparam logic [0:0] st_clear = 1'b1;

    localparam logic [aw:0]        cnt_one   = (aw+1)'(1);
    localparam logic [aw:0]        cnt_full  = (aw+1)'(depth);
    localparam logic [aw-1:0]      ptr_one   = aw'(1);
    localparam logic [s_index-1:0] idx_one   = s_index'(1);
    localparam logic [s_index-1:0] idx_last  = '1;

    logic [0:0]         state;
    logic [aw-1:0]      rd_ptr;
    logic [aw-1:0]      wr_ptr;
    logic [aw:0]        count;
    logic [s_index-1:0] clr_index;

    logic [31:0] mem_pc   [depth];
    logic [31:0] mem_dest [depth];
    logic        mem_taken[depth];

    logic full;
    logic empty;
    logic in_run;
    logic push;
    logic pop;

    assign full   = (count == cnt_full);
    assign empty  = (count == '0);
    assign in_run = (state == st_run);

    // Full is taken before any same-cycle pop, so a full FIFO never accepts.
    assign bus.ex_ready   = in_run && !full && !bus.clear_req;
    assign bus.w_br_op    = in_run && !empty && !bus.pred_stall;
    assign push           = bus.ex_valid && bus.ex_ready;
    assign pop            = bus.w_br_op;

    // Head is masked while empty so stale storage never reaches the predictor.
    assign bus.w_pc       = empty ? '0   : mem_pc[rd_ptr];
    assign bus.w_dest     = empty ? '0   : mem_dest[rd_ptr];
    assign bus.w_taken    = empty ? 1'b0 : mem_taken[rd_ptr];

    assign bus.clr_load   = (state == st_clear);
    assign bus.clear_busy = (state == st_clear);
    assign bus.clr_index  = clr_index;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= bus.ex_pc;
            mem_dest[wr_ptr]  <= bus.ex_dest;
            mem_taken[wr_ptr] <= bus.ex_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= st_run;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            clr_index <= '0;
        end else begin
            case (state)
                st_run: begin
                    if (bus.clear_req) begin
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        count     <= '0;
                        clr_index <= '0;
                        state     <= st_clear;
                    end else begin
                        if (push) wr_ptr <= wr_ptr + ptr_one;
                        if (pop)  rd_ptr <= rd_ptr + ptr_one;
                        if (push && !pop)      count <= count + cnt_one;
                        else if (pop && !push) count <= count - cnt_one;
                    end
                end
                st_clear: begin
                    // Index wraps to 0 on the last entry, ready for the next walk.
                    clr_index <= clr_index + idx_one;
                    if (clr_index == idx_last) state <= st_run;
                end
                default: state <= st_run;
            endcase
        end
    end

`ifdef BP_UPDQ_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_bp_cycles;

    assign bus.stat_updates   = stat_updates;
    assign bus.stat_bp_cycles = stat_bp_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates   <= '0;
            stat_bp_cycles <= '0;
        end else begin
            if (bus.w_br_op)                    stat_updates   <= stat_updates + 32'd1;
            if (bus.ex_valid && !bus.ex_ready)  stat_bp_cycles <= stat_bp_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl: directed scenarios plus random traffic,
// checked against a queue-based model of the update FIFO and clear walk.
module tb_bp_update_ctrl;
    localparam int SIDX    = 4;
    localparam int DEPTH   = 4;
    localparam int ENTRIES = 1 << SIDX;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        tk;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_if #(.s_index(SIDX)) bus ();

    bp_update_ctrl #(.s_index(SIDX), .depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    upd_t        exp_q[$];
    int          clear_left = 0;
    int unsigned n_upd = 0;
    int unsigned n_bp  = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en = 1'b0;
    bit          acc_ok = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares every cycle's outputs with the model and drains the scoreboard.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            bit   m_run;
            bit   m_wr;
            upd_t e;
            m_run  = (clear_left == 0);
            acc_ok = m_run && (exp_q.size() < DEPTH) && !bus.clear_req;
            m_wr   = m_run && (exp_q.size() > 0) && !bus.pred_stall;
            check("ex_ready",   64'(bus.ex_ready),   64'(acc_ok));
            check("w_br_op",    64'(bus.w_br_op),    64'(m_wr));
            check("clr_load",   64'(bus.clr_load),   64'(!m_run));
            check("clear_busy", 64'(bus.clear_busy), 64'(!m_run));
            check("clr_index",  64'(bus.clr_index),  64'(m_run ? 0 : ENTRIES - clear_left));
`ifdef BP_UPDQ_STATS_EN
            check("stat_updates",   64'(bus.stat_updates),   64'(n_upd));
            check("stat_bp_cycles", 64'(bus.stat_bp_cycles), 64'(n_bp));
`endif
            if (m_wr) begin
                e = exp_q.pop_front();
                check("w_pc",    64'(bus.w_pc),    64'(e.pc));
                check("w_dest",  64'(bus.w_dest),  64'(e.dest));
                check("w_taken", 64'(bus.w_taken), 64'(e.tk));
                n_upd++;
            end
            if (bus.ex_valid && !acc_ok) n_bp++;
        end
    end

    // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] dest,
                         input logic tk, input logic stall, input logic clr);
        bus.ex_valid   = v;
        bus.ex_pc      = pc;
        bus.ex_dest    = dest;
        bus.ex_taken   = tk;
        bus.pred_stall = stall;
        bus.clear_req  = clr;
        @(negedge clk);
        #2;
        if (clear_left == 0) begin
            if (clr) begin
                exp_q.delete();
                clear_left = ENTRIES;
            end else if (v && acc_ok) begin
                exp_q.push_back('{pc: pc, dest: dest, tk: tk});
            end
        end else begin
            clear_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic stall);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, stall, 1'b0);
    endtask

    task automatic offer_until_accepted(input logic [31:0] pc, input logic [31:0] dest,
                                        input logic tk, input logic stall);
        int tries;
        tries = 0;
        do begin
            cycle(1'b1, pc, dest, tk, stall, 1'b0);
            tries++;
        end while (!acc_ok && tries < 40);
        if (!acc_ok) begin
            n_checks++;
            $display("FAIL accept_timeout: got not-accepted expected accepted within 40 cycles");
        end
    endtask

    initial begin
        bus.ex_valid   = 1'b0;
        bus.ex_pc      = '0;
        bus.ex_dest    = '0;
        bus.ex_taken   = 1'b0;
        bus.pred_stall = 1'b0;
        bus.clear_req  = 1'b0;

        #2;
        check("rst_ex_ready",   64'(bus.ex_ready),   64'(1));
        check("rst_clear_busy", 64'(bus.clear_busy), 64'(0));
        check("rst_w_br_op",    64'(bus.w_br_op),    64'(0));
        check("rst_clr_load",   64'(bus.clr_load),   64'(0));
        check("rst_clr_index",  64'(bus.clr_index),  64'(0));
        check("rst_w_pc",       64'(bus.w_pc),       64'(0));
        check("rst_w_dest",     64'(bus.w_dest),     64'(0));
        check("rst_w_taken",    64'(bus.w_taken),    64'(0));
`ifdef BP_UPDQ_STATS_EN
        check("rst_stat_updates",   64'(bus.stat_updates),   64'(0));
        check("rst_stat_bp_cycles", 64'(bus.stat_bp_cycles), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single update, one-cycle latency, then idle.
        cycle(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Backpressure: fill under stall, 5th held off, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), i[0], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h1004, 32'h2004, 1'b1, 1'b1, 1'b0);
        offer_until_accepted(32'h1004, 32'h2004, 1'b1, 1'b0);
        idle(6, 1'b0);
`ifdef BP_UPDQ_STATS_EN
        check("stat_updates_bp_scenario", 64'(bus.stat_updates), 64'(6));
`endif

        // Clear with queued entries, plus a second clear_req mid-walk.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h3000 + 32'(i), 32'h4000 + 32'(i), 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h3fff, 32'h4fff, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < ENTRIES; i++)
            cycle(1'b1, 32'h5000, 32'h6000, 1'b0, i[1], (i == 6) ? 1'b1 : 1'b0);
        idle(4, 1'b0);

        // Reset in the middle of a walk.
        cycle(1'b1, 32'h7000, 32'h8000, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        while (clear_left > 9) idle(1, 1'b0);
        check("walk_index_before_rst", 64'(bus.clr_index), 64'(7));
        rst = 1'b1;
        #1;
        check("rst_mid_clear_busy", 64'(bus.clear_busy), 64'(0));
        check("rst_mid_clr_index",  64'(bus.clr_index),  64'(0));
        check("rst_mid_clr_load",   64'(bus.clr_load),   64'(0));
        check("rst_mid_ex_ready",   64'(bus.ex_ready),   64'(1));
        exp_q.delete();
        clear_left = 0;
        n_upd      = 0;
        n_bp       = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 4) != 0, $urandom, $urandom, 1'($urandom),
                  ($urandom % 3) == 0, ($urandom % 80) == 0);
        idle(ENTRIES + DEPTH + 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Update scheduler for the branch predictor write port. Accepts resolved-branch updates from EX through a valid/ready handshake, buffers them in a small in-order FIFO, and drains at most one per cycle into the predictor's write port (`w_br_op`/`w_pc`/`w_dest`/`w_taken`) whenever the predictor is not stalled. It also sequences a full-table clear by walking every predictor index. It sits between EX and the branch predictor and is the only driver of the predictor's write and clear inputs.

## Interface
- `s_index`, default 4: predictor index width; the clear walk covers 2^s_index entries.
- `depth`, default 4: FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: EX presents a resolved branch.
- `ex_pc` in 32: PC of the branch.
- `ex_dest` in 32: computed target.
- `ex_taken` in 1: branch outcome.
- `ex_ready` out 1: update accepted this cycle if `ex_valid`.
- `pred_stall` in 1: predictor write port unavailable; hold the FIFO head.
- `clear_req` in 1: one-cycle pulse; invalidate all predictor state.
- `clear_busy` out 1: clear walk in progress.
- `w_br_op` out 1: predictor write strobe.
- `w_pc` out 32: predictor write PC.
- `w_dest` out 32: predictor write target.
- `w_taken` out 1: predictor write outcome.
- `clr_load` out 1: predictor clear strobe.
- `clr_index` out s_index: index being cleared.
- `stat_updates` out 32: writes issued. Present only under the configuration macro.
- `stat_bp_cycles` out 32: backpressure cycles. Present only under the configuration macro.

## Operation
- States: `RUN` and `CLEAR`. Reset enters `RUN` with the FIFO empty and `clr_index` = 0.
- `ex_ready` = (state==`RUN`) && !full && !clear_req.
  - Full is evaluated before the same-cycle pop, so a full FIFO never accepts, even when it pops that cycle.
- Enqueue when `ex_valid` && `ex_ready`: `{ex_pc, ex_dest, ex_taken}` is written at the tail.
- `w_br_op` = (state==`RUN`) && !empty && !pred_stall.
  - `w_pc`, `w_dest` and `w_taken` are the FIFO head, driven combinationally.
  - The head pops on every cycle `w_br_op` is 1.
- `w_pc`, `w_dest` and `w_taken` show the head contents even when `w_br_op` is 0. When the FIFO is empty their values are don't-care but must be 0 after reset.
- Order is strict FIFO. There is no coalescing of duplicate PCs.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- `clear_req` in `RUN`:
  - At the next edge: discard all FIFO entries, set `clr_index` = 0, go to `CLEAR`.
  - An `ex_valid` in the same cycle is not accepted (`ex_ready` = 0).
  - A `w_br_op` issued in that cycle still completes.
- `CLEAR`:
  - `clr_load` = 1, `clear_busy` = 1, `ex_ready` = 0, `w_br_op` = 0.
  - `clr_index` increments each cycle regardless of `pred_stall`.
  - In the cycle where `clr_index` = 2^s_index-1, transition to `RUN` at the edge and set `clr_index` to 0.
  - `clear_req` during `CLEAR` is ignored; the walk is not restarted.
- Read and write pointers are log2(depth) bits and wrap naturally. Full and empty are derived from a count of log2(depth)+1 bits.
- `rst` asserted mid-walk or with entries queued: immediately return to the reset state; all queued updates are lost.

## Timing
- Reset values:
  - `ex_ready` = 1, unless `clear_req` is high.
  - `clear_busy` = 0, `w_br_op` = 0, `clr_load` = 0, `clr_index` = 0.
  - `w_pc` = 0, `w_dest` = 0, `w_taken` = 0.
  - Stat counters = 0.
- Update latency: an update accepted at edge N drives `w_br_op` in cycle N+1, provided the FIFO was empty and `pred_stall` = 0.
- Throughput: one accept and one drain per cycle.
- Clear: `clear_req` sampled at edge N gives `clr_load` high for cycles N+1 through N+2^s_index. `ex_ready` can return to 1 in cycle N+2^s_index+1.

## Configuration
- `BP_UPDQ_STATS_EN` defined:
  - `stat_updates` increments on each `w_br_op` cycle.
  - `stat_bp_cycles` increments on each cycle with `ex_valid` && !`ex_ready`.
  - Both wrap at 2^32 and reset to 0 on `rst` only; `clear_req` does not reset them.
- Not defined: both ports and both counters are absent, and the behaviour of all other outputs is unchanged.

## Test plan
- Single update: `ex_valid` for one cycle with pc=0x100, dest=0x200, taken=1. Next cycle `w_br_op`=1 with the same values; the cycle after, `w_br_op`=0.
- Backpressure: hold `pred_stall`=1 and offer 5 updates. `depth`=4 are accepted, the 5th sees `ex_ready`=0. Release the stall: 4 consecutive `w_br_op` cycles in enqueue order, then the 5th is accepted.
- Full with simultaneous pop: fill 4 entries, set `pred_stall`=0 and offer `ex_valid` in the same cycle. `ex_ready`=0 that cycle and 1 the next.
- Clear: queue 3 entries under stall, pulse `clear_req`. 16 cycles of `clr_load` with `clr_index` 0..15, no `w_br_op` afterward, then `ex_ready`=1.
- Clear collisions: second `clear_req` mid-walk leaves the walk length at 16. Asserting `rst` at `clr_index`=7 gives `clear_busy`=0 and `clr_index`=0 immediately.
- Stats (`BP_UPDQ_STATS_EN`): the backpressure scenario gives `stat_updates`=5; `stat_bp_cycles` equals the number of stalled-offer cycles.
